// File: rtl/n1_pkg.sv
// Shared opcode encoding and default datapath constants for the tt_um_n1 neuron.
package n1_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_WR_W  = 3'b001,
    OP_WR_B  = 3'b010,
    OP_CLEAR = 3'b011,
    OP_MAC   = 3'b100,
    OP_FIRE  = 3'b101
  } opcode_e;

  localparam int N1_ACC_W = 24;
  localparam int N1_SHIFT = 4;
  localparam int N1_N_W   = 8;

endpackage

// File: rtl/n1_mac.sv
// Accumulator datapath: MAC, bias preload, floor shift, int8 saturation and activation.
// Optional ReLU activation is compiled in with N1_RELU_EN.
module n1_mac
  import n1_pkg::*;
#(
  parameter int ACC_W = N1_ACC_W,
  parameter int SHIFT = N1_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_mac,
  input  logic       i_fire,
  input  logic [7:0] i_x,
  input  logic [7:0] i_w,
  input  logic [7:0] i_bias,
  output logic [7:0] o_res
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  logic signed [ACC_W-1:0] r_acc;
  logic        [7:0]       r_res;

  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic        [7:0]       w_sat;
  logic        [7:0]       w_act;

  // Full 16-bit signed product, widened so the sum wraps at ACC_W.
  assign w_prod     = $signed(i_x) * $signed(i_w);
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-8){i_bias[7]}}, i_bias} <<< SHIFT;
  assign w_shifted  = r_acc >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[7:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = 8'h7F;
    end else if (w_shifted < SAT_MIN) begin
      w_sat = 8'h80;
    end
  end

`ifdef N1_RELU_EN
  assign w_act = w_sat[7] ? 8'h00 : w_sat;
`else
  assign w_act = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= w_bias_ext;
    end else if (i_mac) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (i_fire) begin
      r_res <= w_act;
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/tt_um_n1.sv
// Single 8-input int8 neuron: command decode plus weight/bias storage around n1_mac.
// Build with N1_RELU_EN to clamp negative results to zero.
module tt_um_n1
  import n1_pkg::*;
#(
  parameter int ACC_W = N1_ACC_W,
  parameter int SHIFT = N1_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] r_weight [N1_N_W];
  logic [7:0] r_bias;

  logic [2:0] w_op;
  logic [2:0] w_addr;
  logic       w_wr_w;
  logic       w_wr_b;
  logic       w_clear;
  logic       w_mac;
  logic       w_fire;
  logic       w_unused_rsv;

  // Command word: [2:0] opcode, [4:3] reserved, [7:5] weight address.
  assign w_op         = uio_in[2:0];
  assign w_addr       = uio_in[7:5];
  assign w_unused_rsv = ^uio_in[4:3];

  // Opcodes 110/111 decode to nothing, so they act as NOP.
  assign w_wr_w  = ena && (w_op == OP_WR_W);
  assign w_wr_b  = ena && (w_op == OP_WR_B);
  assign w_clear = ena && (w_op == OP_CLEAR);
  assign w_mac   = ena && (w_op == OP_MAC);
  assign w_fire  = ena && (w_op == OP_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N1_N_W; i++) begin
        r_weight[i] <= '0;
      end
    end else if (w_wr_w) begin
      r_weight[w_addr] <= ui_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias <= '0;
    end else if (w_wr_b) begin
      r_bias <= ui_in;
    end
  end

  n1_mac #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_mac   (w_mac),
    .i_fire  (w_fire),
    .i_x     (ui_in),
    .i_w     (r_weight[w_addr]),
    .i_bias  (r_bias),
    .o_res   (uo_out)
  );

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_n1.sv
// Self-checking bench for tt_um_n1: directed vector table, reset corner cases, random commands.
module tb_tt_um_n1;
  import n1_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

`ifdef N1_RELU_EN
  localparam logic [7:0] E_NEG5 = 8'h00;
  localparam logic [7:0] E_M1   = 8'h00;
  localparam logic [7:0] E_SATN = 8'h00;
  localparam logic [7:0] E_BN2  = 8'h00;
`else
  localparam logic [7:0] E_NEG5 = 8'hFB;
  localparam logic [7:0] E_M1   = 8'hFF;
  localparam logic [7:0] E_SATN = 8'h80;
  localparam logic [7:0] E_BN2  = 8'hFE;
`endif

  typedef struct {
    logic       e;
    logic [7:0] x;
    logic [2:0] op;
    logic [2:0] addr;
    logic [1:0] rsv;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  tt_um_n1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Driver: one command per cycle; expected result queued, popped after the edge.
  task automatic do_cmd(input logic e, input logic [7:0] x, input logic [2:0] op,
                        input logic [2:0] addr, input logic [1:0] rsv,
                        input logic [7:0] exp, input string name);
    logic [7:0] want;
    @(negedge clk);
    ena    = e;
    ui_in  = x;
    uio_in = {addr, rsv, op};
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = exp_q.pop_front();
      check(name, uo_out, want);
    end
  endtask

  // Reference model for the random phase
  longint m_w[8];
  longint m_bias;
  longint m_acc;
  logic [7:0] m_res;

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & 64'h0000_0000_00FF_FFFF;
    if (m >= 64'h80_0000) m = m - 64'h100_0000;
    return m;
  endfunction

  function automatic logic [7:0] fire_val(input longint acc);
    longint s;
    s = acc >>> 4;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef N1_RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    // Reset state before any clock edge
    #2;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    #10;
    rst_n = 1'b1;

    // Basic
    vecs.push_back('{1'b1, 8'd16,  OP_WR_W,  3'd0, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 8'd3,   OP_WR_B,  3'd0, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 8'd5,   OP_MAC,   3'd0, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, 8'h08});
    // Enable gating: acc must stay at 128
    vecs.push_back('{1'b0, 8'd0,   OP_CLEAR, 3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b0, 8'd5,   OP_MAC,   3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b0, 8'd0,   OP_FIRE,  3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b0, 8'd99,  OP_WR_W,  3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b1, 8'd5,   OP_MAC,   3'd0, 2'b00, 8'h08});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, 8'h0D});
    // Negative
    vecs.push_back('{1'b1, 8'hF0,  OP_WR_W,  3'd1, 2'b00, 8'h0D});
    vecs.push_back('{1'b1, 8'd0,   OP_WR_B,  3'd0, 2'b00, 8'h0D});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b00, 8'h0D});
    vecs.push_back('{1'b1, 8'd5,   OP_MAC,   3'd1, 2'b00, 8'h0D});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, E_NEG5});
    // Floor of -1/16 is -1; reserved bits ignored
    vecs.push_back('{1'b1, 8'hFF,  OP_WR_W,  3'd3, 2'b11, E_NEG5});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b10, E_NEG5});
    vecs.push_back('{1'b1, 8'd1,   OP_MAC,   3'd3, 2'b01, E_NEG5});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b11, E_M1});
    // Positive saturation
    vecs.push_back('{1'b1, 8'h7F,  OP_WR_W,  3'd2, 2'b00, E_M1});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b00, E_M1});
    vecs.push_back('{1'b1, 8'h7F,  OP_MAC,   3'd2, 2'b00, E_M1});
    vecs.push_back('{1'b1, 8'h7F,  OP_MAC,   3'd2, 2'b00, E_M1});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, 8'h7F});
    // Negative saturation
    vecs.push_back('{1'b1, 8'h80,  OP_WR_W,  3'd2, 2'b00, 8'h7F});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b00, 8'h7F});
    vecs.push_back('{1'b1, 8'h7F,  OP_MAC,   3'd2, 2'b00, 8'h7F});
    vecs.push_back('{1'b1, 8'h7F,  OP_MAC,   3'd2, 2'b00, 8'h7F});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, E_SATN});
    // Opcodes 110/111 are NOPs; negative bias preload
    vecs.push_back('{1'b1, 8'h55,  3'b110,   3'd0, 2'b00, E_SATN});
    vecs.push_back('{1'b1, 8'h55,  3'b111,   3'd0, 2'b00, E_SATN});
    vecs.push_back('{1'b1, 8'hFE,  OP_WR_B,  3'd0, 2'b00, E_SATN});
    vecs.push_back('{1'b1, 8'd0,   OP_CLEAR, 3'd0, 2'b00, E_SATN});
    vecs.push_back('{1'b1, 8'd0,   OP_FIRE,  3'd0, 2'b00, E_BN2});

    for (int i = 0; i < vecs.size(); i++) begin
      do_cmd(vecs[i].e, vecs[i].x, vecs[i].op, vecs[i].addr, vecs[i].rsv,
             vecs[i].exp, $sformatf("vec[%0d]", i));
    end

    // Mid-operation reset between MAC and FIRE
    do_cmd(1'b1, 8'd16, OP_WR_W,  3'd0, 2'b00, E_BN2, "mid_wr_w");
    do_cmd(1'b1, 8'd3,  OP_WR_B,  3'd0, 2'b00, E_BN2, "mid_wr_b");
    do_cmd(1'b1, 8'd0,  OP_CLEAR, 3'd0, 2'b00, E_BN2, "mid_clear");
    do_cmd(1'b1, 8'd5,  OP_MAC,   3'd0, 2'b00, E_BN2, "mid_mac");
    do_cmd(1'b1, 8'd0,  OP_FIRE,  3'd0, 2'b00, 8'h08, "mid_fire");
    do_cmd(1'b1, 8'd0,  OP_CLEAR, 3'd0, 2'b00, 8'h08, "mid_clear2");
    do_cmd(1'b1, 8'd5,  OP_MAC,   3'd0, 2'b00, 8'h08, "mid_mac2");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo_out", uo_out, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_cmd(1'b1, 8'd0, OP_FIRE, 3'd0, 2'b00, 8'h00, "post_reset_fire");
    do_cmd(1'b1, 8'd7, OP_MAC,  3'd0, 2'b00, 8'h00, "post_reset_mac");
    do_cmd(1'b1, 8'd0, OP_FIRE, 3'd0, 2'b00, 8'h00, "post_reset_fire2");

    // Random commands against the model (state is all-zero after reset)
    for (int i = 0; i < 8; i++) m_w[i] = 0;
    m_bias = 0;
    m_acc  = 0;
    m_res  = 8'h00;
    for (int n = 0; n < 120; n++) begin
      logic       e;
      logic [2:0] op;
      logic [2:0] addr;
      logic [7:0] x;
      e    = ($urandom_range(0, 9) != 0);
      op   = 3'($urandom_range(0, 7));
      addr = 3'($urandom_range(0, 7));
      x    = 8'($urandom_range(0, 255));
      if (e) begin
        case (op)
          3'b001: m_w[addr] = longint'($signed(x));
          3'b010: m_bias = longint'($signed(x));
          3'b011: m_acc = wrap_acc(m_bias * 16);
          3'b100: m_acc = wrap_acc(m_acc + longint'($signed(x)) * m_w[addr]);
          3'b101: m_res = fire_val(m_acc);
          default: ;
        endcase
      end
      do_cmd(e, x, op, addr, 2'($urandom_range(0, 3)), m_res, $sformatf("rand[%0d]", n));
    end

    check("final_uio_out", uio_out, 8'h00);
    check("final_uio_oe", uio_oe, 8'h00);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_n1.md
TT_UM_N1 -- requirements
Module: tt_um_n1

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width in bits, signed.
REQ-003 SHALL have parameter SHIFT, default 4: arithmetic right shift applied before output quantisation.
REQ-004 SHALL have port ena  input  1: enable; when 0, all commands are ignored.
REQ-005 SHALL have port ui_in  input  8: signed int8 operand (weight, bias or activation x).
REQ-006 SHALL have port uio_in  input  8: command; [2:0] opcode, [4:3] reserved (ignored), [7:5] weight address 0..7.
REQ-007 SHALL have port uo_out  output  8: registered int8 neuron result.
REQ-008 SHALL have port uio_out  output  8: constant 0.
REQ-009 SHALL have port uio_oe  output  8: constant 0 (all uio pins are inputs).

Function
REQ-010 SHALL implement a single 8-input neuron holding: weight[0..7] (int8), bias (int8), acc (signed ACC_W), res (8 bit).
REQ-011 SHALL sample one command per rising clk edge when ena=1, with effect visible after that edge.
REQ-012 Opcode 000 NOP SHALL leave all state unchanged.
REQ-013 Opcode 001 WR_W SHALL set weight[addr] <= ui_in.
REQ-014 Opcode 010 WR_B SHALL set bias <= ui_in.
REQ-015 Opcode 011 CLEAR SHALL set acc <= sign_ext(bias) << SHIFT, using the bias value held before this edge.
REQ-016 Opcode 100 MAC SHALL set acc <= acc + signed(ui_in) * signed(weight[addr]), with a full 16-bit signed product, sign-extended, and two's-complement wrap at ACC_W.
REQ-017 Opcode 101 FIRE SHALL set res <= act(sat8(acc >>> SHIFT)); acc unchanged; uo_out = res, so latency is one edge.
REQ-018 Opcodes 110 and 111 SHALL behave as NOP.
REQ-019 sat8 SHALL clamp to -128..127; the arithmetic shift floors.
REQ-020 act SHALL be the identity unless RELU_EN is defined (see Configuration).
REQ-021 uo_out SHALL change only on FIRE or reset.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, clear all weights, bias, acc and res to 0, giving uo_out=0.
REQ-023 A reset mid-sequence SHALL discard the partial accumulation; the first command after release is honoured on the first rising edge with rst_n=1.

Configuration
REQ-024 SHALL compile ReLU in with macro N1_RELU_EN.
REQ-025 With N1_RELU_EN defined, act(v) SHALL be v if v>0, else 0, giving a result range 0..127.
REQ-026 Without N1_RELU_EN, act SHALL be the identity, giving a result range -128..127.

Structure
REQ-027 Package n1_pkg SHALL hold the opcode enum (NOP, WR_W, WR_B, CLEAR, MAC, FIRE) and the default ACC_W/SHIFT constants.
REQ-028 Sub-module n1_mac SHALL hold the acc register, multiplier, shift, saturation and activation; top-level tt_um_n1 SHALL hold command decode and the weight/bias registers.

Verification
REQ-029 Reset: assert rst_n=0 with no clock -> uo_out=0x00, uio_out=0x00, uio_oe=0x00.
REQ-030 Basic: WR_W addr0=16, WR_B=3, CLEAR, MAC x=5 addr0, FIRE -> uo_out=0x08 (80>>>4=5, +3).
REQ-031 Negative: WR_W addr1=0xF0 (-16), WR_B=0, CLEAR, MAC x=5 addr1, FIRE -> uo_out=0xFB without N1_RELU_EN; 0x00 with it.
REQ-032 Saturation: weight[2]=127, CLEAR with bias 0, two MAC x=127 addr2, FIRE -> acc=32258, uo_out=0x7F; repeat with weight=-128 -> 0x80 (or 0x00 with N1_RELU_EN).
REQ-033 Enable gating: after a FIRE yielding 0x08, hold ena=0 while issuing CLEAR, MAC and FIRE -> uo_out stays 0x08 and acc is unchanged.
REQ-034 Mid-operation reset: pulse rst_n low between a MAC and FIRE -> uo_out=0 immediately; a subsequent FIRE yields 0x00.
